karatsuba64_seq: RTL and testbench
==================================

Name: karatsuba64_seq

Overview:
- Sequencing and recombination stage for the 64x64 Karatsuba multiplier.
- Accepts a 64-bit operand pair and drives one shared karatsuba34 core three times, one pass per partial product z0, z2 and z1.
- Consumes each 68-bit core product and recombines the three into a 128-bit result.
- Sits directly around the karatsuba34 core: upstream it feeds the core's start/A/B, downstream it consumes the core's P/valid_out.

Parameters:
- TIMEOUT_CYCLES, 64: maximum number of cycles spent waiting for core valid per pass before aborting with err.

Ports:
- clk  in  1  system clock; all logic is on the rising edge.
- rst  in  1  reset, asynchronous and active-high.
- start  in  1  one-cycle request; sampled only in IDLE.
- A  in  64  multiplicand, captured on the accepted start.
- B  in  64  multiplier, captured on the accepted start.
- busy  out  1  high from the cycle after an accepted start until valid_out or err.
- P  out  128  product; holds its value until the next accepted start.
- valid_out  out  1  one-cycle pulse when P is valid.
- err  out  1  one-cycle pulse when a core pass times out.
- k_start  out  1  start to the karatsuba34 core.
- k_A  out  34  operand A to the core.
- k_B  out  34  operand B to the core.
- k_P  in  68  product from the core.
- k_valid  in  1  core valid_out.

Behaviour:
- Reset: state IDLE; P=0; busy, valid_out, err, k_start all 0; k_A=k_B=0; captured operands and partial products cleared.
- Operand split: a1=A[63:32], a0=A[31:0]; b1=B[63:32], b0=B[31:0].
  - Pass order: z0 = a0*b0, then z2 = a1*b1, then z1raw = (a1+a0)*(b1+b0).
  - The 33-bit sums are zero-extended to 34 bits. z0 and z2 operands are zero-extended to 34 bits.
- States: IDLE, ISS0, WT0, ISS2, WT2, ISS1, WT1, COMB, DONE.
- IDLE: start=1 captures A and B, next state is ISS0. start while not in IDLE is ignored and does not re-capture.
- ISSx: one cycle. k_start=1; k_A/k_B carry the pass operands, which stay stable through the matching WTx. The wait counter is cleared.
- WTx:
  - k_valid is sampled every cycle. The first cycle with k_valid=1 latches k_P into the matching z register and advances to the next ISS, or to COMB after WT1.
  - k_valid outside the WT states is ignored.
  - Timeout: if k_valid stays 0 for TIMEOUT_CYCLES cycles in one WT state, err pulses for one cycle, the state returns to IDLE, P is unchanged and valid_out is not asserted.
- COMB: z1 = z1raw - z2 - z0, taken modulo 2^68; the true value is nonnegative and below 2^66. Then P_next = (z2<<64) + (z1<<32) + z0, computed at 130 bits and truncated to 128 bits (the true result always fits). P updates at the end of COMB.
- DONE: valid_out=1 for exactly one cycle and busy drops the same cycle; next state is IDLE.
  - A start in the cycle after DONE is accepted, giving back-to-back operation with one IDLE cycle.
- Latency: with core latency Lk (k_start cycle to k_valid cycle, Lk>=1), valid_out rises 3*(Lk+1)+2 cycles after the accepted start edge.
- Reset mid-operation: immediate abort to reset values. No valid_out or err is produced for the aborted job.
- Simultaneous k_valid and timeout expiry in the same cycle: k_valid wins.

Test Plan:
- A=B=0x0000_0000_0FFF_FFFF with a real core → P=0x0000_0000_0000_0000_00FF_FFFF_E000_0001; one valid_out pulse; busy high throughout.
- A=B=0xFFFF_FFFF_FFFF_FFFF → P=0xFFFF_FFFF_FFFF_FFFE_0000_0000_0000_0001; the z1 pass sees k_A=k_B=0x1_FFFF_FFFE.
- A=0x8000_0000_0000_0000, B=2 → P=0x0000_0000_0000_0001_0000_0000_0000_0000. Then A=0 with any B → P=0; both jobs back-to-back.
- Core model with Lk=5: check exact latency of 3*6+2=20 cycles. A second start pulsed while busy is ignored, and P matches the first job's operands.
- Stub core that never raises k_valid, TIMEOUT_CYCLES=8 → err pulses 8 cycles after ISS0, valid_out stays 0, P keeps its previous value, next job completes normally.
- Assert rst during WT2 → all outputs return to 0 immediately. After release, a new job A=3, B=5 gives P=15.

Source files
------------

// File: rtl/karatsuba64_seq.sv
// karatsuba64_seq: sequences three karatsuba34 core passes and recombines them into a 128-bit product
module karatsuba64_seq #(
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [63:0]  A,
    input  logic [63:0]  B,
    output logic         busy,
    output logic [127:0] P,
    output logic         valid_out,
    output logic         err,
    output logic         k_start,
    output logic [33:0]  k_A,
    output logic [33:0]  k_B,
    input  logic [67:0]  k_P,
    input  logic         k_valid
);
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    typedef enum logic [3:0] {IDLE, ISS0, WT0, ISS2, WT2, ISS1, WT1, COMB, DONE} state_t;
    state_t state, state_nx;
    logic [63:0] a_r, b_r;
    logic [67:0] z0, z2, z1r, z1;
    logic [127:0] p_nx;
    logic [CW-1:0] cnt;
    logic in_wt, tmo;
    // state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end
    // next state, core handshake and status outputs; a core valid beats a timeout in the same cycle
    always_comb begin
        in_wt = (state == WT0) || (state == WT2) || (state == WT1);
        tmo = in_wt && !k_valid && (cnt == CW'(TIMEOUT_CYCLES - 1));
        err = tmo;
        valid_out = (state == DONE);
        busy = (state != IDLE) && (state != DONE) && !tmo;
        k_start = (state == ISS0) || (state == ISS2) || (state == ISS1);
        k_A = (state == ISS0 || state == WT0) ? 34'(a_r[31:0]) :
              (state == ISS2 || state == WT2) ? 34'(a_r[63:32]) :
              (state == ISS1 || state == WT1) ? 34'(a_r[63:32]) + 34'(a_r[31:0]) : '0;
        k_B = (state == ISS0 || state == WT0) ? 34'(b_r[31:0]) :
              (state == ISS2 || state == WT2) ? 34'(b_r[63:32]) :
              (state == ISS1 || state == WT1) ? 34'(b_r[63:32]) + 34'(b_r[31:0]) : '0;
        state_nx = state;
        case (state)
            IDLE:    state_nx = start ? ISS0 : IDLE;
            ISS0:    state_nx = WT0;
            WT0:     state_nx = k_valid ? ISS2 : tmo ? IDLE : WT0;
            ISS2:    state_nx = WT2;
            WT2:     state_nx = k_valid ? ISS1 : tmo ? IDLE : WT2;
            ISS1:    state_nx = WT1;
            WT1:     state_nx = k_valid ? COMB : tmo ? IDLE : WT1;
            COMB:    state_nx = DONE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end
    // recombination: the middle term wraps mod 2^68 and the final sum is taken mod 2^128
    always_comb begin
        z1 = z1r - z2 - z0;
        p_nx = 128'({z2, 64'b0}) + 128'({z1, 32'b0}) + 128'(z0);
    end
    // operand capture, wait counter, partial-product latches and result register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_r <= '0;
            b_r <= '0;
            cnt <= '0;
            z0  <= '0;
            z2  <= '0;
            z1r <= '0;
            P   <= '0;
        end else begin
            if (state == IDLE && start) begin
                a_r <= A;
                b_r <= B;
            end
            cnt <= in_wt ? cnt + 1'b1 : '0;
            if (state == WT0 && k_valid) z0 <= k_P;
            if (state == WT2 && k_valid) z2 <= k_P;
            if (state == WT1 && k_valid) z1r <= k_P;
            if (state == COMB) P <= p_nx;
        end
    end
endmodule

// File: tb/tb_karatsuba64_seq.sv
// tb_karatsuba64_seq: directed vectors plus corner sequences against a behavioural karatsuba34 core
module tb_karatsuba64_seq;
    logic clk = 0, rst, start;
    logic [63:0] A, B;
    logic busy, valid_out, err, k_start, k_valid;
    logic [127:0] P;
    logic [33:0] k_A, k_B;
    logic [67:0] k_P;
    int n_cmp = 0, n_fail = 0;
    int core_lat = 1;
    bit dead = 0;
    logic [67:0] prod = '0;
    int cd = 0;
    logic [101:0] sha = '0, shb = '0;

    typedef struct {
        logic [63:0]  a;
        logic [63:0]  b;
        int           lat;
        logic [127:0] p;
    } vec_t;
    vec_t vt [7];

    karatsuba64_seq #(.TIMEOUT_CYCLES(8)) dut (
        .clk(clk), .rst(rst), .start(start), .A(A), .B(B), .busy(busy), .P(P),
        .valid_out(valid_out), .err(err), .k_start(k_start), .k_A(k_A), .k_B(k_B),
        .k_P(k_P), .k_valid(k_valid)
    );

    always #5 clk = ~clk;

    // core model: product after core_lat cycles, garbage on k_P when not valid
    always @(posedge clk) begin
        if (k_start) begin
            prod <= 68'(k_A) * 68'(k_B);
            cd <= core_lat;
            sha <= {sha[67:0], k_A};
            shb <= {shb[67:0], k_B};
        end else if (cd > 0) cd <= cd - 1;
    end
    assign k_valid = (cd == 1) && !dead;
    assign k_P = k_valid ? prod : 68'hF0F0F0F0F0F0F0F0F;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic run_job(input logic [63:0] a, input logic [63:0] b, input int lat, input int glitch,
                           output int cyc, output bit gv, output bit ge, output bit bok,
                           output bit sok, output bit pok);
        core_lat = lat;
        A = a; B = b; start = 1; bok = 1; sok = 1;
        @(negedge clk);
        start = 0; A = ~a; B = ~b; cyc = 1;
        while (cyc < 200 && !valid_out && !err) begin
            if (!busy) bok = 0;
            if (k_valid && (k_A !== sha[33:0] || k_B !== shb[33:0])) sok = 0;
            start = (cyc == glitch);
            if (start) begin
                A = 64'h5555_5555_5555_5555;
                B = A;
            end
            @(negedge clk);
            cyc++;
        end
        start = 0; gv = valid_out; ge = err;
        if (busy) bok = 0;
        @(negedge clk);
        pok = !valid_out && !err;
    endtask

    initial begin
        int cyc;
        bit gv, ge, bok, sok, pok, quiet;
        logic [127:0] prev;
        rst = 1; start = 0; A = '0; B = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_P", P, '0);
        chk("reset_ctl", {busy, valid_out, err, k_start, k_A, k_B}, '0);
        rst = 0;
        vt[0] = '{64'h0000_0000_0FFF_FFFF, 64'h0000_0000_0FFF_FFFF, 1, 128'h0000_0000_0000_0000_00FF_FFFF_E000_0001};
        vt[1] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 5, 128'hFFFF_FFFF_FFFF_FFFE_0000_0000_0000_0001};
        vt[2] = '{64'h8000_0000_0000_0000, 64'h2, 2, 128'h0000_0000_0000_0001_0000_0000_0000_0000};
        vt[3] = '{64'h0, 64'hDEAD_BEEF_0123_4567, 3, 128'h0};
        vt[4] = '{64'h0000_0001_0000_0001, 64'h0000_0001_0000_0001, 8, 128'h0000_0000_0000_0001_0000_0002_0000_0001};
        vt[5] = '{64'hFFFF_FFFF_0000_0000, 64'h0000_0000_FFFF_FFFF, 4, 128'h0000_0000_FFFF_FFFE_0000_0001_0000_0000};
        vt[6] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1, 128'h0000_0000_0000_0000_FFFF_FFFF_FFFF_FFFF};
        for (int i = 0; i < 7; i++) begin
            run_job(vt[i].a, vt[i].b, vt[i].lat, 0, cyc, gv, ge, bok, sok, pok);
            chk($sformatf("v%0d_valid_err", i), {gv, ge}, 2'b10);
            chk($sformatf("v%0d_latency", i), cyc, 3 * (vt[i].lat + 1) + 2);
            chk($sformatf("v%0d_P", i), P, vt[i].p);
            chk($sformatf("v%0d_kA_passes", i), sha,
                {34'(vt[i].a[31:0]), 34'(vt[i].a[63:32]), 34'(vt[i].a[63:32]) + 34'(vt[i].a[31:0])});
            chk($sformatf("v%0d_kB_passes", i), shb,
                {34'(vt[i].b[31:0]), 34'(vt[i].b[63:32]), 34'(vt[i].b[63:32]) + 34'(vt[i].b[31:0])});
            chk($sformatf("v%0d_busy_stable_pulse", i), {bok, sok, pok}, 3'b111);
            if (vt[i].a == '1 && vt[i].b == '1)
                chk("z1_operands_allF", {sha[33:0], shb[33:0]}, {2{34'h1_FFFF_FFFE}});
        end
        run_job(64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 5, 4, cyc, gv, ge, bok, sok, pok);
        chk("busy_start_valid", {gv, ge}, 2'b10);
        chk("busy_start_latency", cyc, 20);
        chk("busy_start_P", P, 128'h0000_0000_0000_0000_FFFF_FFFF_FFFF_FFFF);
        chk("busy_start_flags", {bok, sok, pok}, 3'b111);
        prev = P;
        dead = 1;
        run_job(64'h3, 64'h5, 5, 0, cyc, gv, ge, bok, sok, pok);
        dead = 0;
        chk("timeout_valid_err", {gv, ge}, 2'b01);
        chk("timeout_cycle", cyc, 9);
        chk("timeout_P_held", P, prev);
        chk("timeout_busy_pulse", {bok, pok}, 2'b11);
        run_job(64'h2, 64'h3, 1, 0, cyc, gv, ge, bok, sok, pok);
        chk("after_timeout_valid", {gv, ge}, 2'b10);
        chk("after_timeout_P", P, 128'd6);
        core_lat = 5;
        A = 64'h0000_0007_0000_0003; B = 64'h0000_0009_0000_0005; start = 1;
        @(negedge clk);
        start = 0;
        repeat (8) @(negedge clk);
        chk("wt2_kA", k_A, 34'h7);
        rst = 1;
        #1;
        chk("midreset_P", P, '0);
        chk("midreset_ctl", {busy, valid_out, err, k_start, k_A, k_B}, '0);
        @(negedge clk);
        rst = 0;
        quiet = 1;
        repeat (20) begin
            @(negedge clk);
            if (valid_out || err || busy) quiet = 0;
        end
        chk("aborted_job_silent", quiet, 1'b1);
        run_job(64'h3, 64'h5, 2, 0, cyc, gv, ge, bok, sok, pok);
        chk("post_reset_valid", {gv, ge}, 2'b10);
        chk("post_reset_P", P, 128'd15);
        chk("post_reset_latency", cyc, 11);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
